dma_word_mover: RTL and testbench

- DMA-side master for the data memory's DMA port; drives the dma_* address/data lines and the read/write ownership selects.
- Moves a block of 32-bit words inside data memory, in one of two modes:
  - copy: src to dst;
  - fill: constant to dst.
- Requests the memory from the CPU through a req/gnt pair and reports busy, done and error to the control/CSR logic.

---
 rtl/dma_word_mover.sv | 147 ++++++++++++++
 tb/tb_dma_word_mover.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_word_mover.sv
// DMA word mover: copies (src->dst) or fills (constant->dst) a block of data-memory words over the DMA port.
// Copy moves one word per 2 granted cycles, fill one per granted cycle; a dropped grant freezes the current step.
module dma_word_mover #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int NUM_WORDS       = 128,
  parameter int LEN_WIDTH       = 8
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rst_n,
  input  logic                       dma_start,
  input  logic                       dma_mode,
  input  logic [DATA_ADDR_WIDTH-1:0] dma_src_addr,
  input  logic [DATA_ADDR_WIDTH-1:0] dma_dst_addr,
  input  logic [LEN_WIDTH-1:0]       dma_len,
  input  logic [DATA_WIDTH-1:0]      dma_fill_data,
  output logic                       dma_busy,
  output logic                       dma_done,
  output logic                       dma_error,
  output logic                       dma_bus_req,
  input  logic                       dma_bus_gnt,
  input  logic [DATA_WIDTH-1:0]      data_mem_rdata,
  output logic [DATA_ADDR_WIDTH-1:0] dma_data_mem_raddr,
  output logic [DATA_ADDR_WIDTH-1:0] dma_data_mem_waddr,
  output logic [DATA_WIDTH-1:0]      dma_data_mem_wdata,
  output logic                       data_mem_write,
  output logic                       data_mem_read_ctrl_by,
  output logic                       data_mem_write_ctrl_by
);

  typedef enum logic [2:0] {IDLE, CHECK, REQ, READ, WRITE, DONE} state_t;

  // One extra bit so that base + length can never wrap past the memory limit.
  localparam int SUM_WIDTH = DATA_ADDR_WIDTH + 1;
  localparam logic [SUM_WIDTH-1:0] MEM_WORDS = SUM_WIDTH'(NUM_WORDS);

  state_t                     state, state_next;
  logic                       mode;
  logic [DATA_ADDR_WIDTH-1:0] src_ptr, dst_ptr;
  logic [LEN_WIDTH-1:0]       remaining;
  logic [DATA_WIDTH-1:0]      fill_word, word_buf;
  logic                       err_flag;
  logic [SUM_WIDTH-1:0]       src_end, dst_end;
  logic                       range_bad;

  assign src_end   = SUM_WIDTH'(src_ptr) + SUM_WIDTH'(remaining);
  assign dst_end   = SUM_WIDTH'(dst_ptr) + SUM_WIDTH'(remaining);
  assign range_bad = (dst_end > MEM_WORDS) || (!mode && (src_end > MEM_WORDS));

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) state <= IDLE;
    else            state <= state_next;
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      mode      <= 1'b0;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      fill_word <= '0;
      word_buf  <= '0;
      err_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dma_start) begin
            mode      <= dma_mode;
            src_ptr   <= dma_src_addr;
            dst_ptr   <= dma_dst_addr;
            remaining <= dma_len;
            fill_word <= dma_fill_data;
            err_flag  <= 1'b0;
          end
        end
        CHECK: err_flag <= (remaining != '0) && range_bad;
        READ: begin
          if (dma_bus_gnt) word_buf <= data_mem_rdata;
        end
        WRITE: begin
          if (dma_bus_gnt) begin
            src_ptr   <= src_ptr + DATA_ADDR_WIDTH'(1);
            dst_ptr   <= dst_ptr + DATA_ADDR_WIDTH'(1);
            remaining <= remaining - LEN_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next             = state;
    dma_busy               = 1'b0;
    dma_done               = 1'b0;
    dma_error              = 1'b0;
    dma_bus_req            = 1'b0;
    dma_data_mem_raddr     = '0;
    dma_data_mem_waddr     = '0;
    dma_data_mem_wdata     = '0;
    data_mem_write         = 1'b0;
    data_mem_read_ctrl_by  = 1'b0;
    data_mem_write_ctrl_by = 1'b0;
    case (state)
      IDLE: begin
        if (dma_start) state_next = CHECK;
      end
      CHECK: begin
        dma_busy   = 1'b1;
        state_next = ((remaining == '0) || range_bad) ? DONE : REQ;
      end
      REQ: begin
        dma_busy    = 1'b1;
        dma_bus_req = 1'b1;
        if (dma_bus_gnt) state_next = mode ? WRITE : READ;
      end
      READ: begin
        dma_busy    = 1'b1;
        dma_bus_req = 1'b1;
        if (dma_bus_gnt) begin
          data_mem_read_ctrl_by = 1'b1;
          dma_data_mem_raddr    = src_ptr;
          state_next            = WRITE;
        end
      end
      WRITE: begin
        dma_busy    = 1'b1;
        dma_bus_req = 1'b1;
        if (dma_bus_gnt) begin
          data_mem_write_ctrl_by = 1'b1;
          data_mem_write         = 1'b1;
          dma_data_mem_waddr     = dst_ptr;
          dma_data_mem_wdata     = mode ? fill_word : word_buf;
          if (remaining == LEN_WIDTH'(1)) state_next = DONE;
          else                            state_next = mode ? WRITE : READ;
        end
      end
      DONE: begin
        dma_done   = 1'b1;
        dma_error  = err_flag;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_word_mover.sv
// Bench for dma_word_mover: data memory and arbiter around the DUT, with a transfer-level model and per-cycle compare.
module tb_dma_word_mover;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NW = 128;
  localparam int LW = 8;

  logic          cpu_clk = 1'b0;
  logic          cpu_rst_n = 1'b0;
  logic          dma_start = 1'b0;
  logic          dma_mode = 1'b0;
  logic [AW-1:0] dma_src_addr = '0;
  logic [AW-1:0] dma_dst_addr = '0;
  logic [LW-1:0] dma_len = '0;
  logic [DW-1:0] dma_fill_data = '0;
  logic          dma_busy, dma_done, dma_error, dma_bus_req;
  logic          dma_bus_gnt = 1'b1;
  logic [DW-1:0] data_mem_rdata;
  logic [AW-1:0] dma_data_mem_raddr, dma_data_mem_waddr;
  logic [DW-1:0] dma_data_mem_wdata;
  logic          data_mem_write, data_mem_read_ctrl_by, data_mem_write_ctrl_by;

  dma_word_mover #(.DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW), .NUM_WORDS(NW), .LEN_WIDTH(LW)) dut (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .dma_start(dma_start), .dma_mode(dma_mode),
    .dma_src_addr(dma_src_addr), .dma_dst_addr(dma_dst_addr), .dma_len(dma_len),
    .dma_fill_data(dma_fill_data), .dma_busy(dma_busy), .dma_done(dma_done), .dma_error(dma_error),
    .dma_bus_req(dma_bus_req), .dma_bus_gnt(dma_bus_gnt), .data_mem_rdata(data_mem_rdata),
    .dma_data_mem_raddr(dma_data_mem_raddr), .dma_data_mem_waddr(dma_data_mem_waddr),
    .dma_data_mem_wdata(dma_data_mem_wdata), .data_mem_write(data_mem_write),
    .data_mem_read_ctrl_by(data_mem_read_ctrl_by), .data_mem_write_ctrl_by(data_mem_write_ctrl_by)
  );

  always #5 cpu_clk = ~cpu_clk;

  int cyc = 0;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Data memory: combinational read, write on posedge.
  logic [DW-1:0] mem [NW];
  logic          scramble = 1'b0;
  logic          pl_we = 1'b0;
  logic [6:0]    pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  always @(posedge cpu_clk) begin
    if (scramble) for (int i = 0; i < NW; i++) mem[i] <= $urandom;
    if (pl_we) mem[pl_addr] <= pl_data;
    if (data_mem_write && dma_data_mem_waddr < NW) mem[dma_data_mem_waddr[6:0]] <= dma_data_mem_wdata;
  end
  assign data_mem_rdata = mem[dma_data_mem_raddr[6:0]];

  // Arbiter: 0 = always grant, 1 = random grant, 2 = grant dropped in [drop_lo, drop_hi].
  int gnt_mode = 0;
  int drop_lo = 0;
  int drop_hi = -1;
  always @(posedge cpu_clk) begin
    #1;
    case (gnt_mode)
      0:       dma_bus_gnt = 1'b1;
      1:       dma_bus_gnt = ($urandom_range(0, 3) != 0);
      default: dma_bus_gnt = !(cyc >= drop_lo && cyc <= drop_hi);
    endcase
  end

  // Transfer-level model: expected write sequence and final memory image.
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];
  logic [DW-1:0] ref_mem [NW];
  logic [DW-1:0] pre_mem [NW];
  bit  exp_err;
  int  exp_lat, exp_len, start_cyc;

  task automatic plan(input bit mode, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                      input int len, input logic [DW-1:0] fill);
    logic [DW-1:0] d;
    for (int i = 0; i < NW; i++) begin
      ref_mem[i] = mem[i];
      pre_mem[i] = mem[i];
    end
    exp_len = len;
    exp_err = (len != 0) && ((longint'(dst) + len > NW) || (!mode && (longint'(src) + len > NW)));
    exp_lat = (len == 0 || exp_err) ? 2 : 3 + len * (mode ? 1 : 2);
    if (!exp_err) begin
      for (int i = 0; i < len; i++) begin
        d = mode ? fill : ref_mem[int'(src) + i];
        ref_mem[int'(dst) + i] = d;
        exp_addr_q.push_back(dst + AW'(i));
        exp_data_q.push_back(d);
      end
    end
  endtask

  // Compare process: per-cycle port rules plus every write against the model queue.
  int done_cnt = 0, done_cyc = 0, wr_cnt = 0, rd_cnt = 0, req_cnt = 0, first_wr = 0, last_wr = 0;
  bit last_err = 1'b0;
  always @(negedge cpu_clk) begin
    if (cpu_rst_n) begin
      chk(!(data_mem_read_ctrl_by && data_mem_write_ctrl_by) &&
          (!(data_mem_read_ctrl_by || data_mem_write_ctrl_by) || dma_bus_gnt),
          "own_select", {data_mem_read_ctrl_by, data_mem_write_ctrl_by, dma_bus_gnt}, 0);
      chk(data_mem_write == data_mem_write_ctrl_by, "write_vs_own",
          {data_mem_write, data_mem_write_ctrl_by}, {data_mem_write_ctrl_by, data_mem_write_ctrl_by});
      chk((data_mem_read_ctrl_by || dma_data_mem_raddr == 0) &&
          (data_mem_write_ctrl_by || (dma_data_mem_waddr == 0 && dma_data_mem_wdata == 0)),
          "unowned_zero", {dma_data_mem_raddr, dma_data_mem_waddr}, 0);
      chk((!dma_error || dma_done) && (!dma_done || (!dma_busy && !dma_bus_req)),
          "done_flags", {dma_done, dma_error, dma_busy, dma_bus_req}, 0);
      if (data_mem_write) begin
        if (wr_cnt == 0) first_wr = cyc;
        last_wr = cyc;
        wr_cnt++;
        if (exp_addr_q.size() == 0) chk(1'b0, "unexpected_write", dma_data_mem_waddr, 0);
        else begin
          chk(dma_data_mem_waddr == exp_addr_q[0] && dma_data_mem_wdata == exp_data_q[0], "write_word",
              {dma_data_mem_waddr, dma_data_mem_wdata}, {exp_addr_q[0], exp_data_q[0]});
          void'(exp_addr_q.pop_front());
          void'(exp_data_q.pop_front());
        end
      end
      if (data_mem_read_ctrl_by) rd_cnt++;
      if (dma_bus_req) req_cnt++;
      if (dma_done) begin
        done_cnt++;
        done_cyc = cyc;
        last_err = dma_error;
      end
    end
  end

  task automatic poke(input int addr, input logic [DW-1:0] data);
    @(negedge cpu_clk);
    pl_we = 1'b1; pl_addr = addr[6:0]; pl_data = data;
    @(negedge cpu_clk);
    pl_we = 1'b0;
  endtask

  task automatic launch(input bit mode, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                        input int len, input logic [DW-1:0] fill);
    @(negedge cpu_clk);
    plan(mode, src, dst, len, fill);
    done_cnt = 0; wr_cnt = 0; rd_cnt = 0; req_cnt = 0;
    dma_mode = mode; dma_src_addr = src; dma_dst_addr = dst;
    dma_len = len[LW-1:0]; dma_fill_data = fill; dma_start = 1'b1;
    start_cyc = cyc;
    @(negedge cpu_clk);
    dma_start = 1'b0;
  endtask

  task automatic finish(input string name, input bit check_lat, input int extra);
    int budget;
    int bad;
    budget = 0;
    while (done_cnt == 0 && budget < 500) begin
      @(negedge cpu_clk); #2;
      budget++;
    end
    repeat (2) @(negedge cpu_clk);
    #2;
    chk(done_cnt == 1, {name, "_done_pulse"}, done_cnt, 1);
    chk(last_err == exp_err, {name, "_error"}, last_err, exp_err);
    if (check_lat) chk(done_cyc - start_cyc == exp_lat + extra, {name, "_latency"},
                       done_cyc - start_cyc, exp_lat + extra);
    chk(exp_addr_q.size() == 0, {name, "_all_written"}, exp_addr_q.size(), 0);
    bad = 0;
    for (int i = 0; i < NW; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk(bad == 0, {name, "_mem_image"}, bad, 0);
    if (exp_err || exp_len == 0) chk(req_cnt == 0 && wr_cnt == 0, {name, "_no_access"}, {req_cnt, wr_cnt}, 0);
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: actual hung required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s, b, bad;
    logic [AW-1:0] src, dst;
    int len;
    bit mode;

    scramble = 1'b1;
    repeat (3) @(negedge cpu_clk);
    scramble = 1'b0;
    chk({dma_busy, dma_done, dma_error, dma_bus_req, dma_data_mem_raddr, dma_data_mem_waddr,
         dma_data_mem_wdata, data_mem_write, data_mem_read_ctrl_by, data_mem_write_ctrl_by} == '0,
        "reset_outputs", {dma_busy, dma_done, dma_bus_req, data_mem_write}, 0);
    cpu_rst_n = 1'b1;

    // Copy with continuous grant.
    poke(4, 11); poke(5, 22); poke(6, 33); poke(7, 44);
    launch(1'b0, 4, 20, 4, 0);
    finish("copy", 1'b1, 0);
    chk(wr_cnt == 4, "copy_writes", wr_cnt, 4);
    chk(done_cyc - start_cyc == 11, "copy_latency_lit", done_cyc - start_cyc, 11);
    chk(mem[20] == 11 && mem[21] == 22 && mem[22] == 33 && mem[23] == 44, "copy_data_lit",
        {mem[20][15:0], mem[21][15:0], mem[22][15:0], mem[23][15:0]}, {16'd11, 16'd22, 16'd33, 16'd44});

    // Fill: back-to-back writes, read port never taken.
    launch(1'b1, 0, 40, 3, 32'hDEADBEEF);
    finish("fill", 1'b1, 0);
    chk(wr_cnt == 3 && last_wr - first_wr == 2, "fill_consecutive", {wr_cnt, last_wr - first_wr}, {3, 2});
    chk(rd_cnt == 0, "fill_no_read", rd_cnt, 0);
    chk(mem[40] == 32'hDEADBEEF && mem[41] == 32'hDEADBEEF && mem[42] == 32'hDEADBEEF, "fill_data_lit",
        mem[42], 32'hDEADBEEF);

    // Grant dropped for 3 cycles in the middle of the first WRITE.
    poke(60, 32'hAA); poke(61, 32'hBB);
    gnt_mode = 2;
    launch(1'b0, 60, 80, 2, 0);
    drop_lo = start_cyc + 4;
    drop_hi = start_cyc + 6;
    repeat (4) @(negedge cpu_clk);
    #2;
    chk(!data_mem_write && !data_mem_read_ctrl_by && !data_mem_write_ctrl_by && dma_bus_req && dma_busy,
        "gdrop_stalled", {data_mem_write, data_mem_read_ctrl_by, data_mem_write_ctrl_by, dma_bus_req}, 1);
    finish("gdrop", 1'b1, 3);
    chk(mem[80] == 32'hAA && mem[81] == 32'hBB, "gdrop_data_lit", {mem[80], mem[81]}, {32'hAA, 32'hBB});
    gnt_mode = 0;

    // Range checks, including exact-fit and 32-bit wrap.
    launch(1'b0, 126, 0, 4, 0);
    finish("range_src", 1'b1, 0);
    chk(last_err == 1'b1 && done_cyc - start_cyc == 2, "range_src_lit", {last_err, done_cyc - start_cyc}, {1'b1, 2});
    launch(1'b1, 0, 32'hFFFF_FFF0, 32, 32'h1);
    finish("range_wrap", 1'b1, 0);
    launch(1'b1, 0, 124, 4, 32'h1234_5678);
    finish("fit_fill", 1'b1, 0);
    launch(1'b0, 124, 0, 4, 0);
    finish("fit_copy", 1'b1, 0);

    // Zero length.
    launch(1'b0, 5, 6, 0, 0);
    finish("zero_len", 1'b1, 0);
    chk(last_err == 1'b0 && req_cnt == 0, "zero_len_lit", {last_err, req_cnt}, 0);

    // Start while busy and start in the DONE cycle are both ignored.
    launch(1'b1, 0, 60, 30, 32'h5A5A_0001);
    s = start_cyc;
    repeat (5) @(negedge cpu_clk);
    dma_mode = 1'b0; dma_src_addr = 0; dma_dst_addr = 100; dma_len = 5; dma_start = 1'b1;
    @(negedge cpu_clk);
    dma_start = 1'b0;
    b = 0;
    while (cyc != s + exp_lat && b < 200) begin @(negedge cpu_clk); b++; end
    dma_start = 1'b1;
    @(negedge cpu_clk);
    dma_start = 1'b0;
    #2;
    chk(!dma_busy, "start_in_done_ignored", dma_busy, 0);
    finish("busy_start", 1'b1, 0);
    chk(!dma_busy && wr_cnt == 30, "busy_start_writes", {dma_busy, wr_cnt}, 30);

    // Reset after 2 of 6 words.
    launch(1'b0, 10, 70, 6, 0);
    repeat (6) @(negedge cpu_clk);
    cpu_rst_n = 1'b0;
    @(negedge cpu_clk);
    chk({dma_busy, dma_done, dma_error, dma_bus_req, dma_data_mem_raddr, dma_data_mem_waddr,
         dma_data_mem_wdata, data_mem_write, data_mem_read_ctrl_by, data_mem_write_ctrl_by} == '0,
        "midreset_outputs", {dma_busy, dma_bus_req, data_mem_write}, 0);
    @(negedge cpu_clk);
    cpu_rst_n = 1'b1;
    repeat (10) @(negedge cpu_clk);
    #2;
    chk(done_cnt == 0 && wr_cnt == 2 && !dma_busy, "midreset_no_done", {done_cnt, wr_cnt}, {0, 2});
    bad = 0;
    for (int i = 0; i < NW; i++)
      if (mem[i] !== ((i == 70) ? pre_mem[10] : (i == 71) ? pre_mem[11] : pre_mem[i])) bad++;
    chk(bad == 0, "midreset_mem", bad, 0);
    exp_addr_q.delete();
    exp_data_q.delete();

    // Randomized transfers with a random grant, including overlapping copies.
    gnt_mode = 1;
    for (int t = 0; t < 25; t++) begin
      mode = 1'($urandom_range(0, 1));
      len  = $urandom_range(0, 16);
      src  = $urandom_range(0, NW - 1);
      dst  = ($urandom_range(0, 3) == 0) ? src + AW'($urandom_range(1, 3)) : AW'($urandom_range(0, NW - 1));
      launch(mode, src, dst, len, $urandom);
      finish("random", 1'b0, 0);
    end
    gnt_mode = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
